// File: rtl/pipe_decode_ctrl.sv
// Decode stage: turns one instruction word per cycle into a registered control bundle,
// inserting a load-use bubble and holding issue while a multi-cycle multiply runs.
module pipe_decode_ctrl #(
    parameter int MUL_LAT  = 4,
    parameter int LU_STALL = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic        flush,
    output logic        ctrl_valid,
    output logic [4:0]  rs_o,
    output logic [4:0]  rt_o,
    output logic [4:0]  rd_o,
    output logic        wr_regfile,
    output logic        imm_sel,
    output logic        mul_start,
    output logic        alu_res_sel,
    output logic        wr_mem,
    output logic        wb_mem_sel,
    output logic        branch,
    output logic        jump,
    output logic [1:0]  alu_sel,
    output logic        illegal,
    output logic        busy
);
    localparam int               CNT_W    = $clog2(MUL_LAT) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd36;
    localparam logic [5:0] OP_BNE   = 6'd37;
    localparam logic [5:0] OP_ADDI  = 6'd38;
    localparam logic [5:0] OP_ORI   = 6'd39;
    localparam logic [5:0] F_ADD    = 6'd32;
    localparam logic [5:0] F_SUB    = 6'd34;
    localparam logic [5:0] F_AND    = 6'd36;
    localparam logic [5:0] F_OR     = 6'd37;
    localparam logic [5:0] F_MULT   = 6'd50;

    typedef enum logic [1:0] {S_RUN, S_LU_STALL, S_MUL_WAIT} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             lw_pend;
    logic [4:0]       lw_rd;

    logic [5:0] op, funct;
    logic [4:0] rs, rt, rd;
    logic       unused_shamt;

    assign op           = instr[31:26];
    assign rs           = instr[25:21];
    assign rt           = instr[20:16];
    assign rd           = instr[15:11];
    assign funct        = instr[5:0];
    assign unused_shamt = ^instr[10:6];

    logic       d_legal, d_wr_regfile, d_imm_sel, d_mul_start, d_alu_res_sel;
    logic       d_wr_mem, d_wb_mem_sel, d_branch, d_jump, d_reads_rs, d_reads_rt;
    logic [1:0] d_alu_sel;
    logic [4:0] d_rs, d_rt, d_rd;

    always_comb begin
        d_legal       = 1'b1;
        d_wr_regfile  = 1'b0;
        d_imm_sel     = 1'b0;
        d_mul_start   = 1'b0;
        d_alu_res_sel = 1'b1;
        d_wr_mem      = 1'b0;
        d_wb_mem_sel  = 1'b0;
        d_branch      = 1'b0;
        d_jump        = 1'b0;
        d_alu_sel     = 2'b00;
        d_rs          = rs;
        d_rt          = rt;
        d_rd          = rt;
        d_reads_rs    = 1'b1;
        d_reads_rt    = 1'b0;
        case (op)
            OP_RTYPE: begin
                d_rd         = rd;
                d_reads_rt   = 1'b1;
                d_wr_regfile = 1'b1;
                case (funct)
                    F_ADD:   d_alu_sel = 2'b00;
                    F_SUB:   d_alu_sel = 2'b01;
                    F_AND:   d_alu_sel = 2'b10;
                    F_OR:    d_alu_sel = 2'b11;
                    F_MULT: begin
                        d_mul_start   = 1'b1;
                        d_alu_res_sel = 1'b0;
                    end
                    default: d_legal = 1'b0;
                endcase
            end
            OP_LW: begin
                d_imm_sel    = 1'b1;
                d_wr_regfile = 1'b1;
                d_wb_mem_sel = 1'b1;
            end
            OP_SW: begin
                d_imm_sel  = 1'b1;
                d_wr_mem   = 1'b1;
                d_rd       = 5'd0;
                d_reads_rt = 1'b1;
            end
            OP_BNE: begin
                d_alu_sel  = 2'b01;
                d_branch   = 1'b1;
                d_rd       = 5'd0;
                d_reads_rt = 1'b1;
            end
            OP_ADDI: begin
                d_imm_sel    = 1'b1;
                d_wr_regfile = 1'b1;
            end
            OP_ORI: begin
                d_alu_sel    = 2'b11;
                d_imm_sel    = 1'b1;
                d_wr_regfile = 1'b1;
            end
            OP_J: begin
                d_jump     = 1'b1;
                d_rs       = 5'd0;
                d_rt       = 5'd0;
                d_rd       = 5'd0;
                d_reads_rs = 1'b0;
            end
            default: d_legal = 1'b0;
        endcase
    end

    // lw_pend is high exactly while the LW bundle sits on the outputs
    logic hazard, issue;
    assign hazard = (LU_STALL != 0) && lw_pend && instr_valid &&
                    ((d_reads_rs && (rs == lw_rd)) || (d_reads_rt && (rt == lw_rd)));
    assign instr_ready = !rst && (state != S_MUL_WAIT) && !hazard;
    assign issue       = instr_valid && instr_ready && !flush;
    assign busy        = !rst && (state != S_RUN);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (flush) begin
            state_nxt = S_RUN;
            cnt_nxt   = '0;
        end else begin
            case (state)
                S_RUN, S_LU_STALL: begin
                    state_nxt = S_RUN;
                    if (hazard) begin
                        state_nxt = S_LU_STALL;
                    end else if (issue && d_legal && d_mul_start && (MUL_LAT > 1)) begin
                        state_nxt = S_MUL_WAIT;
                        cnt_nxt   = CNT_LOAD;
                    end
                end
                S_MUL_WAIT: begin
                    if (cnt <= CNT_ONE) begin
                        state_nxt = S_RUN;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt - CNT_ONE;
                    end
                end
                default: begin
                    state_nxt = S_RUN;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_RUN;
            cnt     <= '0;
            lw_pend <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            lw_pend <= issue && d_legal && (op == OP_LW) && (rt != 5'd0);
        end
    end

    always_ff @(posedge clk) begin
        lw_rd <= rt;
    end

    // output register: bundle on a legal issue, bubble otherwise
    always_ff @(posedge clk) begin
        if (rst || !issue || !d_legal) begin
            ctrl_valid  <= 1'b0;
            rs_o        <= 5'd0;
            rt_o        <= 5'd0;
            rd_o        <= 5'd0;
            wr_regfile  <= 1'b0;
            imm_sel     <= 1'b0;
            mul_start   <= 1'b0;
            alu_res_sel <= 1'b0;
            wr_mem      <= 1'b0;
            wb_mem_sel  <= 1'b0;
            branch      <= 1'b0;
            jump        <= 1'b0;
            alu_sel     <= 2'b00;
        end else begin
            ctrl_valid  <= 1'b1;
            rs_o        <= d_rs;
            rt_o        <= d_rt;
            rd_o        <= d_rd;
            wr_regfile  <= d_wr_regfile;
            imm_sel     <= d_imm_sel;
            mul_start   <= d_mul_start;
            alu_res_sel <= d_alu_res_sel;
            wr_mem      <= d_wr_mem;
            wb_mem_sel  <= d_wb_mem_sel;
            branch      <= d_branch;
            jump        <= d_jump;
            alu_sel     <= d_alu_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) illegal <= 1'b0;
        else     illegal <= issue && !d_legal;
    end
endmodule

// File: tb/tb_pipe_decode_ctrl.sv
// Scoreboard bench for pipe_decode_ctrl: two configurations share one stimulus stream and
// are checked cycle by cycle against a cycle-numbered reference model.
module tb_pipe_decode_ctrl;
    localparam logic [31:0] I_ADD   = 32'h0043_5020;
    localparam logic [31:0] I_LW    = 32'h8FE1_0000;
    localparam logic [31:0] I_ADD51 = 32'h0022_2820;
    localparam logic [31:0] I_MULT  = 32'h0064_0032;
    localparam logic [31:0] I_BADOP = 32'hFC00_0000;
    localparam logic [31:0] I_BADFN = 32'h0000_003F;
    localparam logic [31:0] I_BNE   = 32'h97FE_FFF0;

    logic        clk = 1'b0;
    logic        rst, instr_valid, flush;
    logic [31:0] instr;
    logic [26:0] got0, got1;
    logic        rdy0, rdy1, busy0, busy1;

    always #5 clk = ~clk;

    pipe_decode_ctrl #(.MUL_LAT(4), .LU_STALL(1)) dut0 (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid), .instr_ready(rdy0),
        .flush(flush), .ctrl_valid(got0[26]), .rs_o(got0[25:21]), .rt_o(got0[20:16]),
        .rd_o(got0[15:11]), .wr_regfile(got0[10]), .imm_sel(got0[9]), .mul_start(got0[8]),
        .alu_res_sel(got0[7]), .wr_mem(got0[6]), .wb_mem_sel(got0[5]), .branch(got0[4]),
        .jump(got0[3]), .alu_sel(got0[2:1]), .illegal(got0[0]), .busy(busy0)
    );

    pipe_decode_ctrl #(.MUL_LAT(1), .LU_STALL(0)) dut1 (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid), .instr_ready(rdy1),
        .flush(flush), .ctrl_valid(got1[26]), .rs_o(got1[25:21]), .rt_o(got1[20:16]),
        .rd_o(got1[15:11]), .wr_regfile(got1[10]), .imm_sel(got1[9]), .mul_start(got1[8]),
        .alu_res_sel(got1[7]), .wr_mem(got1[6]), .wb_mem_sel(got1[5]), .branch(got1[4]),
        .jump(got1[3]), .alu_sel(got1[2:1]), .illegal(got1[0]), .busy(busy1)
    );

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    bit mon_en   = 1'b0;

    logic [26:0] bq0[$], bq1[$];
    logic [1:0]  cq0[$], cq1[$];

    int          lat[2] = '{4, 1};
    bit          lus[2] = '{1'b1, 1'b0};
    int          mul_free_at[2] = '{0, 0};
    int          stall_at[2]    = '{-5, -5};
    int          lw_cyc[2]      = '{-5, -5};
    logic [4:0]  lw_dest[2]     = '{5'd0, 5'd0};

    // Bundle packing: {valid, rs, rt, rd, wr_regfile, imm_sel, mul_start, alu_res_sel,
    //                  wr_mem, wb_mem_sel, branch, jump, alu_sel[1:0], illegal}
    function automatic logic [26:0] model_decode(input logic [31:0] w);
        logic [5:0] op  = w[31:26];
        logic [5:0] fn  = w[5:0];
        bit         ok  = 1'b1;
        bit         wr  = 1'b0, imm = 1'b0, mul = 1'b0, ars = 1'b1;
        bit         wm  = 1'b0, wbm = 1'b0, br = 1'b0, jp = 1'b0;
        logic [1:0] alu = 2'b00;
        logic [4:0] a   = w[25:21], b = w[20:16], dst = w[20:16];
        case (op)
            6'd0: begin
                dst = w[15:11];
                wr  = 1'b1;
                if      (fn == 6'd32) alu = 2'b00;
                else if (fn == 6'd34) alu = 2'b01;
                else if (fn == 6'd36) alu = 2'b10;
                else if (fn == 6'd37) alu = 2'b11;
                else if (fn == 6'd50) begin mul = 1'b1; ars = 1'b0; end
                else ok = 1'b0;
            end
            6'd35: begin imm = 1'b1; wr = 1'b1; wbm = 1'b1; end
            6'd36: begin imm = 1'b1; wm = 1'b1; dst = 5'd0; end
            6'd37: begin alu = 2'b01; br = 1'b1; dst = 5'd0; end
            6'd38: begin imm = 1'b1; wr = 1'b1; end
            6'd39: begin alu = 2'b11; imm = 1'b1; wr = 1'b1; end
            6'd2:  begin jp = 1'b1; a = 5'd0; b = 5'd0; dst = 5'd0; end
            default: ok = 1'b0;
        endcase
        if (!ok) return 27'd1;
        return {1'b1, a, b, dst, wr, imm, mul, ars, wm, wbm, br, jp, alu, 1'b0};
    endfunction

    function automatic bit reads_reg(input logic [31:0] w, input logic [4:0] r);
        logic [5:0] op = w[31:26];
        if (op == 6'd2) return 1'b0;
        if (w[25:21] == r) return 1'b1;
        return ((op == 6'd0) || (op == 6'd36) || (op == 6'd37)) && (w[20:16] == r);
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int          ops[10];
        int          fns[6];
        ops = '{0, 0, 35, 35, 36, 37, 38, 39, 2, 63};
        fns = '{32, 34, 36, 37, 50, 63};
        w = $urandom;
        w[31:26] = 6'(ops[$urandom_range(0, 9)]);
        w[25:21] = 5'($urandom_range(0, 3));
        w[20:16] = 5'($urandom_range(0, 3));
        if (w[31:26] == 6'd0) w[5:0] = 6'(fns[$urandom_range(0, 5)]);
        return w;
    endfunction

    task automatic chk(input string nm, input logic [26:0] got, input logic [26:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, got, exp);
        end
    endtask

    // One cycle of stimulus; the model predicts this cycle's ready/busy and next cycle's bundle.
    task automatic step(input bit r, input bit v, input logic [31:0] w, input bit fl);
        bit          blocked, hz, rdy, bsy, iss;
        logic [26:0] nxt;
        rst = r; instr_valid = v; instr = w; flush = fl;
        for (int d = 0; d < 2; d++) begin
            blocked = (cyc < mul_free_at[d]);
            hz  = lus[d] && (lw_cyc[d] == cyc - 1) && (lw_dest[d] != 5'd0) && v &&
                  reads_reg(w, lw_dest[d]);
            rdy = !r && !blocked && !hz;
            bsy = !r && (blocked || (stall_at[d] == cyc));
            iss = rdy && v && !fl;
            nxt = iss ? model_decode(w) : 27'd0;
            if (r) begin
                mul_free_at[d] = 0;
                stall_at[d]    = -5;
                lw_cyc[d]      = -5;
            end else if (fl) begin
                mul_free_at[d] = 0;
            end else begin
                if (hz) stall_at[d] = cyc + 1;
                if (iss && nxt[8] && lat[d] > 1) mul_free_at[d] = cyc + lat[d];
                if (iss && nxt[26] && nxt[5]) begin
                    lw_cyc[d]  = cyc;
                    lw_dest[d] = w[20:16];
                end
            end
            if (d == 0) begin bq0.push_back(nxt); cq0.push_back({rdy, bsy}); end
            else        begin bq1.push_back(nxt); cq1.push_back({rdy, bsy}); end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (bq0.size() == 0 || cq0.size() == 0 || bq1.size() == 0 || cq1.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL scoreboard_empty cyc=%0d got=empty expected=entry", cyc);
            end else begin
                logic [26:0] eb;
                logic [1:0]  ec;
                eb = bq0.pop_front(); ec = cq0.pop_front();
                chk("bundle_d0", got0, eb);
                chk("ready_d0", {26'd0, rdy0}, {26'd0, ec[1]});
                chk("busy_d0", {26'd0, busy0}, {26'd0, ec[0]});
                eb = bq1.pop_front(); ec = cq1.pop_front();
                chk("bundle_d1", got1, eb);
                chk("ready_d1", {26'd0, rdy1}, {26'd0, ec[1]});
                chk("busy_d1", {26'd0, busy1}, {26'd0, ec[0]});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] cur;
        rst = 1'b1; instr_valid = 1'b0; instr = 32'd0; flush = 1'b0;
        @(posedge clk);
        #1;
        bq0.push_back(27'd0);
        bq1.push_back(27'd0);
        mon_en = 1'b1;
        step(1, 0, 0, 0);
        step(1, 1, I_ADD, 0);
        // basic R-type issue, then back-to-back issue
        step(0, 1, I_ADD, 0);
        step(0, 1, I_BNE, 0);
        step(0, 0, 0, 0);
        // load-use: LW r1 then ADD reading r1, held
        step(0, 1, I_LW, 0);
        repeat (3) step(0, 1, I_ADD51, 0);
        step(0, 0, 0, 0);
        // multiply hold-off with ADD waiting behind it
        step(0, 1, I_MULT, 0);
        repeat (5) step(0, 1, I_ADD, 0);
        // flush in the second wait cycle
        step(0, 1, I_MULT, 0);
        step(0, 1, I_ADD, 0);
        step(0, 1, I_ADD, 1);
        repeat (2) step(0, 1, I_ADD, 0);
        // flush together with a load-use hazard
        step(0, 1, I_LW, 0);
        step(0, 1, I_ADD51, 1);
        step(0, 1, I_ADD51, 0);
        step(0, 0, 0, 0);
        // unknown encodings
        step(0, 1, I_BADOP, 0);
        step(0, 0, 0, 0);
        step(0, 1, I_BADFN, 0);
        step(0, 1, I_BNE, 0);
        step(0, 0, 0, 0);
        // reset pulse during multiply wait
        step(0, 1, I_MULT, 0);
        step(0, 0, 0, 0);
        step(1, 1, I_ADD, 0);
        step(0, 1, I_ADD, 0);
        step(0, 0, 0, 0);
        // randomized traffic
        cur = rand_instr();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 1) == 0) cur = rand_instr();
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), cur,
                 ($urandom_range(0, 15) == 0));
        end
        step(0, 0, 0, 0);
        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
